// File: rtl/logic_gates_tester.sv
// Stimulus-and-check engine for a 2-input AND/OR/NOT gate block.
// Define LOGIC_GATES_TESTER_FAILVEC_EN to add the per-vector failure map output oFailVec.
module logic_gates_tester #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iAnd,
    input  logic             iOr,
    input  logic             iNot,
    output logic             oA,
    output logic             oB,
    output logic             oBusy,
    output logic             oDone,
    output logic             oPass,
    output logic [ERR_W-1:0] oErrCnt
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
    ,
    output logic [3:0]       oFailVec
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} stateT;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

    stateT            stateQ, stateD;
    logic [1:0]       vecQ, vecD;
    logic [3:0]       passQ, passD;
    logic [7:0]       settleQ, settleD;
    logic [ERR_W-1:0] errQ, errD;
    logic             busyQ, busyD;
    logic             doneQ, doneD;
    logic             verdictQ, verdictD;
    logic             mismatch;
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
    logic [3:0]       failVecQ, failVecD;
`endif

    // Expected responses come from the registered drives, so they match what the gate sees.
    assign mismatch = (iAnd != (oA & oB)) | (iOr != (oA | oB)) | (iNot != ~oA);

    always_comb begin
        stateD   = stateQ;
        vecD     = vecQ;
        passD    = passQ;
        settleD  = settleQ;
        errD     = errQ;
        busyD    = busyQ;
        doneD    = 1'b0;
        verdictD = verdictQ;
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
        failVecD = failVecQ;
`endif
        case (stateQ)
            IDLE: begin
                if (iStart) begin
                    stateD   = SETTLE;
                    vecD     = '0;
                    passD    = '0;
                    settleD  = '0;
                    errD     = '0;
                    busyD    = 1'b1;
                    verdictD = 1'b0;
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
                    failVecD = '0;
`endif
                end
            end
            SETTLE: begin
                if (settleQ == SETTLE_LAST) begin
                    settleD = '0;
                    stateD  = CHECK;
                end else begin
                    settleD = settleQ + 8'd1;
                end
            end
            CHECK: begin
                if (mismatch && (errQ != '1)) begin
                    errD = errQ + ERR_W'(1);
                end
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
                if (mismatch) begin
                    failVecD[vecQ] = 1'b1;
                end
`endif
                if ((vecQ == 2'd3) && (passQ == PASS_LAST)) begin
                    // Verdict uses the updated count so the final vector's error is included.
                    stateD   = DONE;
                    doneD    = 1'b1;
                    busyD    = 1'b0;
                    verdictD = (errD == '0);
                end else begin
                    vecD   = vecQ + 2'd1;
                    stateD = SETTLE;
                    if (vecQ == 2'd3) begin
                        passD = passQ + 4'd1;
                    end
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vecQ     <= '0;
            passQ    <= '0;
            settleQ  <= '0;
            errQ     <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            verdictQ <= 1'b0;
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
            failVecQ <= '0;
`endif
        end else begin
            vecQ     <= vecD;
            passQ    <= passD;
            settleQ  <= settleD;
            errQ     <= errD;
            busyQ    <= busyD;
            doneQ    <= doneD;
            verdictQ <= verdictD;
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
            failVecQ <= failVecD;
`endif
        end
    end

    assign oA      = vecQ[1];
    assign oB      = vecQ[0];
    assign oBusy   = busyQ;
    assign oDone   = doneQ;
    assign oPass   = verdictQ;
    assign oErrCnt = errQ;
`ifdef LOGIC_GATES_TESTER_FAILVEC_EN
    assign oFailVec = failVecQ;
`endif

endmodule
